// File: rtl/alu_pipe.sv
// Handshaked ALU with a single output register: one-cycle ops, plus an
// iterative barrel-free SHLN/SHRN that shifts one bit per cycle.
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [3:0] OpPassA = 4'h0;
  localparam logic [3:0] OpInc   = 4'h1;
  localparam logic [3:0] OpAdd   = 4'h2;
  localparam logic [3:0] OpSub   = 4'h3;
  localparam logic [3:0] OpDec   = 4'h4;
  localparam logic [3:0] OpPassB = 4'h5;
  localparam logic [3:0] OpAnd   = 4'h6;
  localparam logic [3:0] OpOr    = 4'h7;
  localparam logic [3:0] OpXor   = 4'h8;
  localparam logic [3:0] OpNot   = 4'h9;
  localparam logic [3:0] OpShl1  = 4'hA;
  localparam logic [3:0] OpShr1  = 4'hB;
  localparam logic [3:0] OpShln  = 4'hC;
  localparam logic [3:0] OpShrn  = 4'hD;
  localparam logic [3:0] OpClr   = 4'hE;

  typedef enum logic [1:0] {StIdle, StShift, StFull} state_t;

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_y, w_y_n;
  logic [3:0]         r_flags, w_flags_n;
  logic               r_err, w_err_n;
  logic [WIDTH-1:0]   r_work, w_work_n;
  logic [SHW-1:0]     r_cnt, w_cnt_n;
  logic               r_carry, w_carry_n;
  logic               r_left, w_left_n;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_err;
  logic [3:0]         w_flags;
  logic               w_accept, w_is_shift;

  // Single-cycle datapath; arithmetic is done one bit wider to expose carry.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      OpPassA: w_res = a;
      OpInc: begin
        w_sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~a[WIDTH-1] & w_res[WIDTH-1];
      end
      OpAdd: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c_in};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpDec: begin
        // a + all-ones, so carry stays set unless a was zero
        w_sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = a[WIDTH-1] & ~w_res[WIDTH-1];
      end
      OpPassB: w_res = b;
      OpAnd:   w_res = a & b;
      OpOr:    w_res = a | b;
      OpXor:   w_res = a ^ b;
      OpNot:   w_res = ~a;
      OpShl1: begin
        w_res = a << 1;
        w_c   = a[WIDTH-1];
      end
      OpShr1: begin
        w_res = a >> 1;
        w_c   = a[0];
      end
      OpClr:   w_res = '0;
      OpShln, OpShrn: w_res = '0;
      default: w_err = 1'b1;
    endcase
    w_flags = {w_v, w_c, w_res[WIDTH-1], w_res == '0};
  end

  assign in_ready   = (r_state == StIdle) || ((r_state == StFull) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = (op == OpShln) || (op == OpShrn);

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_flags_n = r_flags;
    w_err_n   = r_err;
    w_work_n  = r_work;
    w_cnt_n   = r_cnt;
    w_carry_n = r_carry;
    w_left_n  = r_left;
    case (r_state)
      StIdle, StFull: begin
        if (w_accept) begin
          if (w_is_shift) begin
            w_state_n = StShift;
            w_work_n  = a;
            w_cnt_n   = b[SHW-1:0];
            w_carry_n = 1'b0;
            w_left_n  = (op == OpShln);
          end else begin
            w_state_n = StFull;
            w_y_n     = w_res;
            w_flags_n = w_flags;
            w_err_n   = w_err;
          end
        end else if (r_state == StFull && out_ready) begin
          w_state_n = StIdle;
        end
      end
      StShift: begin
        if (r_cnt != '0) begin
          if (r_left) begin
            w_carry_n = r_work[WIDTH-1];
            w_work_n  = r_work << 1;
          end else begin
            w_carry_n = r_work[0];
            w_work_n  = r_work >> 1;
          end
          w_cnt_n = r_cnt - SHW'(1);
        end else begin
          w_state_n = StFull;
          w_y_n     = r_work;
          w_flags_n = {1'b0, r_carry, r_work[WIDTH-1], r_work == '0};
          w_err_n   = 1'b0;
        end
      end
      default: w_state_n = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_y     <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_left  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_y     <= w_y_n;
      r_flags <= w_flags_n;
      r_err   <= w_err_n;
      r_work  <= w_work_n;
      r_cnt   <= w_cnt_n;
      r_carry <= w_carry_n;
      r_left  <= w_left_n;
    end
  end

  assign out_valid = (r_state == StFull);
  assign y         = r_y;
  assign flags     = r_flags;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed literal checks plus randomized traffic
// compared every cycle against a latency/result model built from plain arithmetic.
module tb_alu_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sext8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Returns {y[7:0], V, C, N, Z, err}
  function automatic logic [12:0] model_res(input int o, input int ia, input int ib,
                                            input int ci);
    int s, sr, n, yy;
    bit v, c, e;
    v = 0; c = 0; e = 0; yy = 0; s = 0; sr = 0; n = 0;
    case (o)
      0:  yy = ia;
      1:  begin s = ia + 1;  sr = sext8(ia) + 1; end
      2:  begin s = ia + ib + ci; sr = sext8(ia) + sext8(ib) + ci; end
      3:  begin s = ia + (255 - ib) + ci; sr = sext8(ia) - sext8(ib) - 1 + ci; end
      4:  begin s = ia + 255; sr = sext8(ia) - 1; end
      5:  yy = ib;
      6:  yy = ia & ib;
      7:  yy = ia | ib;
      8:  yy = ia ^ ib;
      9:  yy = 255 - ia;
      10, 12: begin
        n  = (o == 10) ? 1 : ib % 8;
        yy = (ia << n) & 255;
        c  = (n == 0) ? 0 : ((ia >> (8 - n)) & 1);
      end
      11, 13: begin
        n  = (o == 11) ? 1 : ib % 8;
        yy = ia >> n;
        c  = (n == 0) ? 0 : ((ia >> (n - 1)) & 1);
      end
      14: yy = 0;
      default: e = 1;
    endcase
    if (o >= 1 && o <= 4) begin
      yy = s % 256;
      c  = (s >= 256);
      v  = (sr > 127) || (sr < -128);
    end
    return {yy[7:0], v, c, yy[7], (yy == 0), e};
  endfunction

  // Model state: m_busy = edges left until a multi-cycle result lands
  bit          mdl_on = 0;
  bit          m_full = 0;
  int          m_busy = 0;
  logic [12:0] m_res  = '0;
  logic [12:0] m_pend = '0;

  initial begin
    bit rdy;
    forever begin
      @(posedge clk);
      if (rst) begin
        mdl_on = 1;
        m_full = 0;
        m_busy = 0;
      end else begin
        rdy = (m_busy == 0) && (!m_full || out_ready);
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_full = 1;
            m_res  = m_pend;
          end
        end else if (in_valid && rdy) begin
          if (op == 4'hC || op == 4'hD) begin
            m_busy = int'(b % 8) + 1;
            m_full = 0;
            m_pend = model_res(int'(op), int'(a), int'(b), int'(c_in));
          end else begin
            m_full = 1;
            m_res  = model_res(int'(op), int'(a), int'(b), int'(c_in));
          end
        end else if (m_full && out_ready) begin
          m_full = 0;
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen reset
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        chk("cmp_out_valid", 32'(out_valid), 32'(m_full));
        chk("cmp_in_ready", 32'(in_ready), 32'((m_busy == 0) && (!m_full || out_ready)));
        if (m_full) begin
          chk("cmp_y", 32'(y), 32'(m_res[12:5]));
          chk("cmp_flags", 32'(flags), 32'(m_res[4:1]));
          chk("cmp_err", 32'(err), 32'(m_res[0]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ci);
    int k;
    in_valid = 1'b1;
    op       = o;
    a        = ia;
    b        = ib;
    c_in     = ci;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      cyc();
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout got in_ready %0h want 1", in_ready);
    end else begin
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [7:0] ey, input logic [3:0] ef,
                         input logic ee);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_y"}, 32'(y), 32'(ey));
    chk({name, "_flags"}, 32'(flags), 32'(ef));
    chk({name, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'h0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;

    // Pin the model with hand-computed results
    chk("mdl_add",  32'(model_res(2, 8'hFF, 8'h01, 0)),  32'({8'h00, 4'b0101, 1'b0}));
    chk("mdl_sub",  32'(model_res(3, 8'h80, 8'h01, 1)),  32'({8'h7F, 4'b1100, 1'b0}));
    chk("mdl_inc",  32'(model_res(1, 8'h7F, 8'h00, 0)),  32'({8'h80, 4'b1010, 1'b0}));
    chk("mdl_dec0", 32'(model_res(4, 8'h00, 8'h00, 0)),  32'({8'hFF, 4'b0010, 1'b0}));
    chk("mdl_shrn", 32'(model_res(13, 8'h81, 8'h09, 0)), 32'({8'h40, 4'b0100, 1'b0}));
    chk("mdl_ill",  32'(model_res(15, 8'h12, 8'h00, 0)), 32'({8'h00, 4'b0001, 1'b1}));

    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    issue(4'h2, 8'hFF, 8'h01, 1'b0);
    chk_out("add", 8'h00, 4'b0101, 1'b0);
    drain();

    issue(4'h3, 8'h80, 8'h01, 1'b1);
    chk_out("sub", 8'h7F, 4'b1100, 1'b0);
    drain();

    out_ready = 1'b1;
    issue(4'hC, 8'h81, 8'h03, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("shln_busy_ready", 32'(in_ready), 32'd0);
      chk("shln_busy_valid", 32'(out_valid), 32'd0);
      cyc();
    end
    chk_out("shln", 8'h08, 4'b0000, 1'b0);
    cyc();

    issue(4'hD, 8'h81, 8'h00, 1'b0);
    chk("shrn0_early", 32'(out_valid), 32'd0);
    cyc();
    chk_out("shrn0", 8'h81, 4'b0010, 1'b0);
    cyc();

    out_ready = 1'b0;
    issue(4'h2, 8'h12, 8'h34, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk_out("hold", 8'h46, 4'b0000, 1'b0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'h8; a = 8'h0F; b = 8'hF0;
    #1;
    chk("passthru_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk_out("b2b_xor", 8'hFF, 4'b0010, 1'b0);
    cyc();

    issue(4'hC, 8'h01, 8'h07, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      cyc();
    end

    out_ready = 1'b0;
    issue(4'hF, 8'h12, 8'h00, 1'b0);
    chk_out("illegal", 8'h00, 4'b0001, 1'b1);
    drain();
    issue(4'h0, 8'h12, 8'h00, 1'b0);
    chk_out("pass_after_ill", 8'h12, 4'b0000, 1'b0);
    drain();

    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      a         = 8'($urandom);
      b         = 8'($urandom);
      c_in      = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
